controle_lampada: RTL
=====================

CONTROLE_LAMPADA -- requirements
Module: controle_lampada

Interface
REQ-001 SHALL have parameter DEBOUNCE_T, default 50, meaning consecutive stable clk cycles before the debounced button level changes (1..65535).
REQ-002 SHALL have parameter LONG_PRESS_T, default 3000, meaning debounced-high clk cycles that classify a press as long (must exceed DEBOUNCE_T, max 65535).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port push_button  input  1  raw, asynchronous pushbutton, high = pressed.
REQ-006 SHALL have port infravermelho  input  1  raw, asynchronous presence sensor, high = presence.
REQ-007 SHALL have port C  input  1  auto-shutdown request from the inactivity-timer stage; sampled directly, no synchronizer.
REQ-008 SHALL have port L  output  1  lamp drive, high = on.
REQ-009 SHALL have port enable  output  1  enable to the inactivity-timer stage.
REQ-010 SHALL have port modo  output  1  current mode, 1 = automatic, 0 = manual.

Function
REQ-011 SHALL pass push_button and infravermelho through separate 2-flop synchronizers before any use.
REQ-012 SHALL change the debounced button level only after the synchronized input has differed from it for DEBOUNCE_T consecutive cycles; any mismatch break restarts the 16-bit count from 0.
REQ-013 SHALL count debounced-high cycles in a 16-bit press counter that saturates at LONG_PRESS_T.
REQ-014 SHALL emit one-cycle long_evt on the cycle the press counter reaches LONG_PRESS_T while held; the release of that press emits nothing.
REQ-015 SHALL emit one-cycle short_evt on the debounced falling edge when the press counter is below LONG_PRESS_T.
REQ-016 SHALL implement a Moore FSM with states AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON; L = 1 only in AUTO_ON and MANUAL_ON; modo = 1 only in AUTO_*.
REQ-017 AUTO_OFF SHALL move to MANUAL_OFF on long_evt, otherwise to AUTO_ON when the synchronized infravermelho is 1.
REQ-018 AUTO_ON SHALL move to MANUAL_ON on long_evt, otherwise to AUTO_OFF when C = 1; short_evt SHALL be ignored in AUTO_*.
REQ-019 MANUAL_OFF SHALL move to MANUAL_ON on short_evt and to AUTO_OFF on long_evt; infravermelho SHALL be ignored in MANUAL_*.
REQ-020 MANUAL_ON SHALL move to MANUAL_OFF on short_evt and to AUTO_OFF on long_evt.
REQ-021 Button events SHALL take priority over C and infravermelho in the same cycle.
REQ-022 enable SHALL be 1 in AUTO_ON and 0 in AUTO_OFF and MANUAL_OFF; MANUAL_ON value is set by REQ-027.
REQ-023 Latency: infravermelho rising to L = 1 in AUTO_OFF SHALL be 3 clk edges (2 synchronizer plus 1 state); C = 1 to L = 0 SHALL be 1 edge.
REQ-024 Unreachable state encodings SHALL return to AUTO_OFF on the next edge.

Reset
REQ-025 While rst = 0, SHALL asynchronously force state AUTO_OFF, synchronizers 0, debounced level 0, both counters 0, and pending events cleared, giving L = 0, enable = 0, modo = 1.
REQ-026 A press in progress when rst asserts SHALL be discarded; after release of rst a still-held button SHALL be debounced and timed from zero.

Configuration
REQ-027 SHALL have macro MANUAL_SHUTDOWN_EN; when defined, enable = 1 in MANUAL_ON and C = 1 moves MANUAL_ON to MANUAL_OFF (REQ-021 priority holds); when undefined, enable = 0 in MANUAL_ON and C is ignored in MANUAL_*.

Verification
(DEBOUNCE_T = 4, LONG_PRESS_T = 20 for all scenarios.)
REQ-028 Reset, then infravermelho = 1 -> L = 1 exactly 3 edges later; then C pulse of 1 cycle -> L = 0 next edge, state AUTO_OFF, enable = 0.
REQ-029 Bounce: button toggling every 2 cycles for 30 cycles, then low -> no event, state unchanged.
REQ-030 Long hold of 25 cycles in AUTO_OFF -> modo = 0 one edge after the 20th debounced-high cycle, L = 0; release produces no short_evt.
REQ-031 In MANUAL_OFF, hold 10 cycles then release -> L = 1 after debounced release; repeat -> L = 0.
REQ-032 MANUAL_ON with C = 1 -> L stays 1 if MANUAL_SHUTDOWN_EN is undefined, L = 0 next edge if defined; C = 1 coincident with long_evt in AUTO_ON -> MANUAL_ON.
REQ-033 rst = 0 asserted mid-hold (count 12) while in MANUAL_ON -> L = 0 and modo = 1 immediately; after release, held button needs the full 4 plus 20 cycles for long_evt.

Source files
------------

// File: rtl/controle_lampada.sv
// Lamp controller: synchronizers, button debounce, short/long press, mode FSM.
// Optional MANUAL_SHUTDOWN_EN: inactivity timer also acts in MANUAL_ON.

module lampada_sync_stage (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

module lampada_debounce_stage #(
  parameter int unsigned DEBOUNCE_T = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam logic [15:0] LAST = 16'(DEBOUNCE_T - 1);

  logic [15:0] cnt;
  logic        hit;

  assign hit  = (din != level) && (cnt == LAST);
  assign fall = hit && level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= 16'd0;
    end else if (din == level) begin
      cnt   <= 16'd0;
    end else if (hit) begin
      level <= din;
      cnt   <= 16'd0;
    end else begin
      cnt   <= cnt + 16'd1;
    end
  end

endmodule

module lampada_press_stage #(
  parameter int unsigned LONG_PRESS_T = 3000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic fall,
  output logic long_evt,
  output logic short_evt
);

  localparam logic [15:0] LIM  = 16'(LONG_PRESS_T);
  localparam logic [15:0] LAST = 16'(LONG_PRESS_T - 1);

  logic [15:0] cnt;

  // A release racing the long threshold counts as long only.
  assign long_evt  = level && (cnt == LAST);
  assign short_evt = fall && (cnt < LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (!level) begin
      cnt <= 16'd0;
    end else if (cnt != LIM) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

module controle_lampada #(
  parameter int unsigned DEBOUNCE_T   = 50,
  parameter int unsigned LONG_PRESS_T = 3000
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  input  logic C,
  output logic L,
  output logic enable,
  output logic modo
);

  typedef enum logic [1:0] {
    AUTO_OFF   = 2'b00,
    AUTO_ON    = 2'b01,
    MANUAL_OFF = 2'b10,
    MANUAL_ON  = 2'b11
  } state_t;

  state_t state;
  state_t state_nx;

  logic pb_s;
  logic ir_s;
  logic pb_lvl;
  logic pb_fall;
  logic long_evt;
  logic short_evt;

  lampada_sync_stage u_pb_sync (
    .clk (clk),
    .rst (rst),
    .d   (push_button),
    .q   (pb_s)
  );

  lampada_sync_stage u_ir_sync (
    .clk (clk),
    .rst (rst),
    .d   (infravermelho),
    .q   (ir_s)
  );

  lampada_debounce_stage #(
    .DEBOUNCE_T (DEBOUNCE_T)
  ) u_deb (
    .clk   (clk),
    .rst   (rst),
    .din   (pb_s),
    .level (pb_lvl),
    .fall  (pb_fall)
  );

  lampada_press_stage #(
    .LONG_PRESS_T (LONG_PRESS_T)
  ) u_press (
    .clk       (clk),
    .rst       (rst),
    .level     (pb_lvl),
    .fall      (pb_fall),
    .long_evt  (long_evt),
    .short_evt (short_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= AUTO_OFF;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      AUTO_OFF: begin
        if (long_evt)  state_nx = MANUAL_OFF;
        else if (ir_s) state_nx = AUTO_ON;
      end
      AUTO_ON: begin
        if (long_evt) state_nx = MANUAL_ON;
        else if (C)   state_nx = AUTO_OFF;
      end
      MANUAL_OFF: begin
        if (long_evt)       state_nx = AUTO_OFF;
        else if (short_evt) state_nx = MANUAL_ON;
      end
      MANUAL_ON: begin
        if (long_evt)       state_nx = AUTO_OFF;
        else if (short_evt) state_nx = MANUAL_OFF;
`ifdef MANUAL_SHUTDOWN_EN
        else if (C)         state_nx = MANUAL_OFF;
`endif
      end
      default: state_nx = AUTO_OFF;
    endcase
  end

  always_comb begin
    L      = 1'b0;
    enable = 1'b0;
    modo   = 1'b0;
    unique case (state)
      AUTO_OFF: begin
        modo = 1'b1;
      end
      AUTO_ON: begin
        modo   = 1'b1;
        L      = 1'b1;
        enable = 1'b1;
      end
      MANUAL_OFF: begin
        L = 1'b0;
      end
      MANUAL_ON: begin
        L = 1'b1;
`ifdef MANUAL_SHUTDOWN_EN
        enable = 1'b1;
`endif
      end
      default: begin
        modo = 1'b1;
      end
    endcase
  end

endmodule
